// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank arbiter: state enum and round-robin pick.
package led_pkg;

  localparam int unsigned NUM_LEDS = 5;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic {IDLE, OWN} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester after 'last' in circular order over n slots; 'last' itself is checked last.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] reqs,
                                       input logic [IDX_W-1:0]   last,
                                       input int unsigned        n);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % n);
      if (i <= n && !pick.found && reqs[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running brightness counter gating the 5-bit LED vector (LED_BANK_PWM_EN build only).
module led_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] gated
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                lit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  // All-ones brightness means fully on, otherwise duty = brightness / 2^PWM_BITS.
  always_comb begin
    lit   = (&brightness) || (pwm_cnt_q < brightness);
    gated = lit ? pattern : '0;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the five board LEDs with a minimum hold time.
// Optional bank dimming is enabled by defining LED_BANK_PWM_EN.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned HOLD_CYCLES = 12000000,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NUM_LEDS*NREQ-1:0] pattern,
  input  logic [PWM_BITS-1:0]      brightness,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     LED0,
  output logic                     LED1,
  output logic                     LED2,
  output logic                     LED3,
  output logic                     LED4
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PAT_W = NUM_LEDS * MAX_REQ;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NREQ-1:0]     grant_q;
  logic                busy_q;
  logic [NUM_LEDS-1:0] led_q;

  logic [MAX_REQ-1:0]  req_ext;
  logic [PAT_W-1:0]    pat_ext;
  logic [NUM_LEDS-1:0] owner_pat;
  logic [NUM_LEDS-1:0] shown;
  rr_pick_t            idle_pick;
  rr_pick_t            hand_pick;
  logic                release_own;

  always_comb begin
    req_ext   = MAX_REQ'(req);
    pat_ext   = PAT_W'(pattern);
    owner_pat = pat_ext[owner_q*NUM_LEDS +: NUM_LEDS];
    idle_pick = rr_next(req_ext, last_q, NREQ);
    // Handover candidates exclude the current owner.
    hand_pick = rr_next(req_ext & ~(MAX_REQ'(1) << owner_q), owner_q, NREQ);
    release_own = !req_ext[owner_q] || ((cnt_q == HOLD_MAX) && hand_pick.found);
  end

`ifdef LED_BANK_PWM_EN
  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rstn      (rstn),
    .brightness(brightness),
    .pattern   (owner_pat),
    .gated     (shown)
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign shown = owner_pat;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      led_q <= (state_q == OWN) ? shown : '0;
      unique case (state_q)
        IDLE: begin
          if (idle_pick.found) begin
            state_q <= OWN;
            owner_q <= idle_pick.idx;
            grant_q <= NREQ'(1) << idle_pick.idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        OWN: begin
          if (release_own) begin
            last_q <= owner_q;
            cnt_q  <= '0;
            if (hand_pick.found) begin
              owner_q <= hand_pick.idx;
              grant_q <= NREQ'(1) << hand_pick.idx;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q != HOLD_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign LED0  = led_q[0];
  assign LED1  = led_q[1];
  assign LED2  = led_q[2];
  assign LED3  = led_q[3];
  assign LED4  = led_q[4];

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed self-checking bench for led_bank_arbiter (NREQ=3, HOLD_CYCLES=4).
module tb_led_bank_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  req;
  logic [14:0] pattern;
  logic [3:0]  brightness;
  logic [2:0]  grant;
  logic        busy;
  logic        LED0, LED1, LED2, LED3, LED4;
  logic [4:0]  leds;

  int checks = 0;
  int errors = 0;

  assign leds = {LED4, LED3, LED2, LED1, LED0};

  led_bank_arbiter #(
    .NREQ       (3),
    .HOLD_CYCLES(4),
    .PWM_BITS   (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .pattern   (pattern),
    .brightness(brightness),
    .grant     (grant),
    .busy      (busy),
    .LED0      (LED0),
    .LED1      (LED1),
    .LED2      (LED2),
    .LED3      (LED3),
    .LED4      (LED4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic b,
                           input logic [4:0] l);
    check_eq({tag, " grant"}, 32'(grant), 32'(g));
    check_eq({tag, " busy"}, 32'(busy), 32'(b));
    check_eq({tag, " leds"}, 32'(leds), 32'(l));
  endtask

  initial begin
    int on_cnt;
    rstn       = 1'b0;
    req        = 3'b000;
    pattern    = '0;
`ifdef LED_BANK_PWM_EN
    brightness = 4'hF;
`else
    brightness = 4'h0;
`endif
    #1;
    check_out("reset", 3'b000, 1'b0, 5'b00000);
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    check_out("idle after release", 3'b000, 1'b0, 5'b00000);

    // Single requester: grant after 1 edge, LEDs after 2.
    pattern = {5'b00000, 5'b10101, 5'b00011};
    req     = 3'b010;
    step();
    check_out("req1 grant", 3'b010, 1'b1, 5'b00000);
    step();
    check_eq("req1 leds", 32'(leds), 32'(5'b10101));
    pattern = {5'b00000, 5'b01110, 5'b00011};
    req     = 3'b011;
    step();
    check_eq("live pattern", 32'(leds), 32'(5'b01110));
    check_eq("non-owner ignored", 32'(grant), 32'(3'b010));
    req = 3'b000;
    step();
    check_out("drop to idle", 3'b000, 1'b0, 5'b01110);
    step();
    check_eq("idle leds", 32'(leds), 32'(5'b00000));

    // Reset restores pointer so first grant goes to requester 0.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    req  = 3'b111;
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq($sformatf("rotate k=%0d", k), 32'(grant), 32'(3'b001 << ((k / 5) % 3)));
    end
    step();
    step();
    check_eq("hold cycle 2", 32'(grant), 32'(3'b001));

    // Owner 0 drops mid-hold with requester 2 waiting.
    pattern = {5'b11001, 5'b01110, 5'b00011};
    req     = 3'b100;
    step();
    check_out("early drop handover", 3'b100, 1'b1, 5'b00011);
    req = 3'b000;
    step();
    check_out("drop no other", 3'b000, 1'b0, 5'b11001);
    step();
    check_eq("leds dark", 32'(leds), 32'(5'b00000));

    // Lone owner keeps the bank past the hold time.
    req = 3'b001;
    for (int k = 0; k < 10; k++) step();
    check_eq("keep indefinitely", 32'(grant), 32'(3'b001));
    check_eq("keep leds", 32'(leds), 32'(5'b00011));

    // Owner drop coincides with an expired hold: single handover.
    req = 3'b010;
    step();
    check_eq("drop+expiry", 32'(grant), 32'(3'b010));
    step();
    check_eq("no double handover", 32'(grant), 32'(3'b010));
    check_eq("owner1 leds", 32'(leds), 32'(5'b01110));

    // Asynchronous reset mid-hold.
    #2;
    rstn = 1'b0;
    #1;
    check_out("async reset", 3'b000, 1'b0, 5'b00000);
    step();
    rstn = 1'b1;
    req  = 3'b111;
    step();
    check_eq("post-reset grant", 32'(grant), 32'(3'b001));

`ifdef LED_BANK_PWM_EN
    req     = 3'b001;
    pattern = {5'b00000, 5'b00000, 5'b11111};
    brightness = 4'd4;
    step();
    step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (leds == 5'b11111) on_cnt++;
      else check_eq("pwm all-or-none", 32'(leds), 32'(5'b00000));
    end
    check_eq("pwm duty 4", 32'(on_cnt), 32'd4);
    brightness = 4'd15;
    step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (leds == 5'b11111) on_cnt++;
    end
    check_eq("pwm full", 32'(on_cnt), 32'd16);
    brightness = 4'd0;
    step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (leds != 5'b00000) on_cnt++;
    end
    check_eq("pwm dark", 32'(on_cnt), 32'd0);
`else
    on_cnt = 0;
    check_eq("brightness ignored", 32'(leds), 32'(5'b00000));
    step();
    check_eq("brightness ignored lit", 32'(leds), 32'(5'b00011));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
